// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: per-stage enables/flushes, load-use bubbles,
// redirect squash, memory-busy freeze, HALT drain, and a saturating stall-cycle counter.
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int REG_AW       = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_halt,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [1:0]       ST_RUN     = 2'd0;
  localparam logic [1:0]       ST_DRAIN   = 2'd1;
  localparam logic [1:0]       ST_HALTED  = 2'd2;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_drain_next;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;
  logic             w_stall_inc;

  assign w_load_use = id_valid & ex_valid & ex_mem_read & ex_reg_write &
                      ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    w_stall_inc  = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mem_busy) begin
            // Full freeze; a pending redirect stays in EX and is re-seen next cycle.
            w_stall_inc = 1'b1;
          end else if (ex_redirect) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            w_stall_inc = 1'b1;
          end else if (id_valid && id_halt) begin
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            w_state_next = ST_DRAIN;
            w_drain_next = DRAIN_LOAD;
          end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
          end
        end
        ST_DRAIN: begin
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = ~mem_busy;
          if (!mem_busy) begin
            if (r_drain_cnt == '0) begin
              w_state_next = ST_HALTED;
            end else begin
              w_drain_next = r_drain_cnt - 1'b1;
            end
          end
        end
        ST_HALTED: begin
        end
        default: begin
          w_state_next = ST_RUN;
          w_drain_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
      r_halted    <= (w_state_next == ST_HALTED);
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign halted    = r_halted;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand-written sequences,
// and randomized traffic compared against a cycle-level reference model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int REG_AW       = 3;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 16;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, id_use_rs, id_use_rt, id_halt;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
  logic              ex_valid, ex_mem_read, ex_reg_write, ex_redirect, mem_busy;
  logic              pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, halted;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_halt(id_halt),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush}
  wire [5:0] w_ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycles of draining left, halted flag, stall total.
  int m_drain_left;
  bit m_halted;
  int m_stalls;

  typedef struct {
    logic             id_valid;
    logic [REG_AW-1:0] id_rs, id_rt;
    logic             use_rs, use_rt, id_halt;
    logic             ex_valid, ex_mem_read, ex_reg_write;
    logic [REG_AW-1:0] ex_rd;
    logic             redirect, busy;
    logic [5:0]       exp_ctrl;
    int               exp_stall;
  } vec_t;

  vec_t vecs[15];

  function automatic bit model_load_use();
    return id_valid && ex_valid && ex_mem_read && ex_reg_write &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  endfunction

  function automatic logic [5:0] model_ctrl();
    if (rst)              return 6'b000011;
    if (m_halted)         return 6'b000000;
    if (m_drain_left > 0) return {3'b001, !mem_busy, 2'b01};
    if (mem_busy)         return 6'b000000;
    if (ex_redirect)      return 6'b111111;
    if (model_load_use()) return 6'b001101;
    if (id_valid && id_halt) return 6'b011110;
    return 6'b111100;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_drain_left = 0;
      m_halted     = 0;
      m_stalls     = 0;
    end else if (m_halted) begin
    end else if (m_drain_left > 0) begin
      if (!mem_busy) begin
        m_drain_left = m_drain_left - 1;
        if (m_drain_left == 0) m_halted = 1;
      end
    end else if (mem_busy || (!ex_redirect && model_load_use())) begin
      if (m_stalls < CNT_MAX) m_stalls = m_stalls + 1;
    end else if (!ex_redirect && id_valid && id_halt) begin
      m_drain_left = DRAIN_CYCLES;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_halt = 0;
    ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; ex_redirect = 0; mem_busy = 0;
  endtask

  // One clock: outputs compared with the model mid-cycle, model advanced on the edge.
  task automatic cycle(input string tag, output logic [5:0] seen);
    @(negedge clk);
    seen = w_ctrl;
    chk({tag, " ctrl"}, {26'd0, w_ctrl}, {26'd0, model_ctrl()});
    chk({tag, " halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk({tag, " stall_cnt"}, {16'd0, stall_cnt}, m_stalls);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc_exp(input string tag, input logic [5:0] exp);
    logic [5:0] seen;
    cycle(tag, seen);
    chk({tag, " ctrl_exp"}, {26'd0, seen}, {26'd0, exp});
    $display("%s: ctrl=%b halted=%0d stall_cnt=%0d", tag, seen, halted, stall_cnt);
  endtask

  task automatic do_reset();
    logic [5:0] seen;
    idle_inputs();
    rst = 1;
    cycle("reset", seen);
    rst = 0;
  endtask

  task automatic apply(input vec_t v);
    id_valid = v.id_valid; id_rs = v.id_rs; id_rt = v.id_rt;
    id_use_rs = v.use_rs; id_use_rt = v.use_rt; id_halt = v.id_halt;
    ex_valid = v.ex_valid; ex_mem_read = v.ex_mem_read; ex_reg_write = v.ex_reg_write;
    ex_rd = v.ex_rd; ex_redirect = v.redirect; mem_busy = v.busy;
  endtask

  function automatic vec_t mk(input logic iv, input int rs, input int rt, input logic urs,
                              input logic urt, input logic hlt, input logic ev, input logic mr,
                              input logic rw, input int rd, input logic rdr, input logic bsy,
                              input logic [5:0] ec, input int es);
    vec_t v;
    v.id_valid = iv; v.id_rs = REG_AW'(rs); v.id_rt = REG_AW'(rt);
    v.use_rs = urs; v.use_rt = urt; v.id_halt = hlt;
    v.ex_valid = ev; v.ex_mem_read = mr; v.ex_reg_write = rw; v.ex_rd = REG_AW'(rd);
    v.redirect = rdr; v.busy = bsy; v.exp_ctrl = ec; v.exp_stall = es;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] seen;
    idle_inputs();
    rst = 1;
    m_drain_left = 0; m_halted = 0; m_stalls = 0;
    @(posedge clk);
    model_edge();
    #1;
    cyc_exp("rst_hold", 6'b000011);
    rst = 0;

    //            iv rs rt urs urt hlt ev mr rw rd rdr bsy  ctrl       stall
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111100, 0);
    vecs[1]  = mk(1, 3, 1, 1, 0, 0, 1, 1, 1, 3, 0, 0, 6'b001101, 1);
    vecs[2]  = mk(1, 2, 5, 1, 1, 0, 1, 1, 1, 5, 0, 0, 6'b001101, 1);
    vecs[3]  = mk(1, 3, 1, 0, 0, 0, 1, 1, 1, 3, 0, 0, 6'b111100, 0);
    vecs[4]  = mk(1, 3, 1, 1, 0, 0, 1, 0, 1, 3, 0, 0, 6'b111100, 0);
    vecs[5]  = mk(1, 3, 1, 1, 0, 0, 1, 1, 0, 3, 0, 0, 6'b111100, 0);
    vecs[6]  = mk(1, 3, 1, 1, 0, 0, 0, 1, 1, 3, 0, 0, 6'b111100, 0);
    vecs[7]  = mk(0, 3, 1, 1, 0, 0, 1, 1, 1, 3, 0, 0, 6'b111100, 0);
    vecs[8]  = mk(1, 0, 4, 1, 0, 0, 1, 1, 1, 0, 0, 0, 6'b001101, 1);
    vecs[9]  = mk(1, 3, 1, 1, 0, 1, 1, 1, 1, 3, 1, 0, 6'b111111, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 6'b000000, 1);
    vecs[11] = mk(1, 3, 1, 1, 0, 0, 1, 1, 1, 3, 0, 1, 6'b000000, 1);
    vecs[12] = mk(1, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'b011110, 0);
    vecs[13] = mk(0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'b111100, 0);
    vecs[14] = mk(1, 6, 2, 1, 0, 1, 1, 1, 1, 6, 0, 0, 6'b001101, 1);

    for (int i = 0; i < 15; i++) begin
      do_reset();
      apply(vecs[i]);
      cyc_exp($sformatf("vec%0d", i), vecs[i].exp_ctrl);
      chk($sformatf("vec%0d stall_after", i), {16'd0, stall_cnt}, vecs[i].exp_stall);
      chk($sformatf("vec%0d halted_after", i), {31'd0, halted}, 32'd0);
    end

    // Load-use: one bubble, then the load sits in MEM and the pipe resumes.
    do_reset();
    apply(vecs[1]);
    cyc_exp("lu_bubble", 6'b001101);
    chk("lu stall_after_bubble", {16'd0, stall_cnt}, 32'd1);
    ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0;
    cyc_exp("lu_resume", 6'b111100);
    chk("lu stall_after_resume", {16'd0, stall_cnt}, 32'd1);

    // Memory freeze holds a pending redirect for 4 cycles.
    do_reset();
    ex_valid = 1; ex_redirect = 1; mem_busy = 1;
    for (int k = 0; k < 4; k++) cyc_exp($sformatf("freeze%0d", k), 6'b000000);
    chk("freeze stall", {16'd0, stall_cnt}, 32'd4);
    mem_busy = 0;
    cyc_exp("freeze_redirect", 6'b111111);
    chk("freeze stall_after_redirect", {16'd0, stall_cnt}, 32'd4);

    // Halt drain without memory stalls: halted visible at t+4.
    do_reset();
    id_valid = 1; id_halt = 1;
    cyc_exp("halt_t", 6'b011110);
    idle_inputs();
    ex_redirect = 1;
    cyc_exp("drain_t1", 6'b001101);
    cyc_exp("drain_t2", 6'b001101);
    chk("drain halted_before_last", {31'd0, halted}, 32'd0);
    cyc_exp("drain_t3", 6'b001101);
    chk("drain halted_t4", {31'd0, halted}, 32'd1);
    cyc_exp("halted_t4", 6'b000000);

    // Halt drain with two busy cycles: halted visible at t+6.
    do_reset();
    id_valid = 1; id_halt = 1;
    cyc_exp("halt2_t", 6'b011110);
    idle_inputs();
    mem_busy = 1;
    cyc_exp("drain2_t1", 6'b001001);
    cyc_exp("drain2_t2", 6'b001001);
    mem_busy = 0;
    cyc_exp("drain2_t3", 6'b001101);
    cyc_exp("drain2_t4", 6'b001101);
    chk("drain2 halted_t5", {31'd0, halted}, 32'd0);
    cyc_exp("drain2_t5", 6'b001101);
    chk("drain2 halted_t6", {31'd0, halted}, 32'd1);
    chk("drain2 stall_unchanged", {16'd0, stall_cnt}, 32'd0);

    // Reset recovery from HALTED with stall_cnt=7.
    do_reset();
    mem_busy = 1;
    for (int k = 0; k < 7; k++) cycle("pre_busy", seen);
    mem_busy = 0; id_valid = 1; id_halt = 1;
    cycle("pre_halt", seen);
    idle_inputs();
    for (int k = 0; k < 4; k++) cycle("pre_drain", seen);
    chk("recov halted_before", {31'd0, halted}, 32'd1);
    chk("recov stall_before", {16'd0, stall_cnt}, 32'd7);
    rst = 1;
    cyc_exp("recov_rst", 6'b000011);
    rst = 0;
    chk("recov halted_after", {31'd0, halted}, 32'd0);
    chk("recov stall_after", {16'd0, stall_cnt}, 32'd0);
    cyc_exp("recov_run", 6'b111100);

    // Saturation of the stall counter.
    do_reset();
    mem_busy = 1;
    for (int k = 0; k < 65536; k++) cycle("sat", seen);
    chk("sat stall_max", {16'd0, stall_cnt}, 32'h0000FFFF);
    cycle("sat_hold", seen);
    chk("sat stall_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
    $display("saturation: stall_cnt=%0h after 65537 busy cycles", stall_cnt);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(63) == 0);
      id_valid     = ($urandom_range(3) != 0);
      id_rs        = REG_AW'($urandom_range(3));
      id_rt        = REG_AW'($urandom_range(3));
      id_use_rs    = 1'($urandom);
      id_use_rt    = 1'($urandom);
      id_halt      = ($urandom_range(15) == 0);
      ex_valid     = ($urandom_range(3) != 0);
      ex_mem_read  = 1'($urandom);
      ex_reg_write = ($urandom_range(3) != 0);
      ex_rd        = REG_AW'($urandom_range(3));
      ex_redirect  = ($urandom_range(7) == 0);
      mem_busy     = ($urandom_range(3) == 0);
      cycle("rand", seen);
    end
    $display("random: 3000 cycles applied");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
